// File: rtl/alu_uart_ctrl.sv
// alu_uart_ctrl: collects operand A, operand B and an opcode byte from a UART
// receiver, presents them to an external combinational ALU, and hands the
// one-byte result to a UART transmitter. A partial operand sequence that goes
// quiet for too long is abandoned so the host can resynchronise.
module alu_uart_ctrl #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout,
  output logic               o_overrun
);

  localparam int NB_CNT = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t            state;
  logic [NB_CNT-1:0] idle_cnt;

  // Busy whenever a result is being computed or is in flight to the transmitter.
  assign o_busy = (state == EXEC) || (state == SEND) || (state == WAIT_TX);

  // Byte-collection / transmit-handshake FSM with registered pulse outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= WAIT_A;
      idle_cnt   <= '0;
      o_alu_a    <= '0;
      o_alu_b    <= '0;
      o_alu_op   <= '0;
      o_tx_data  <= '0;
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; the defaults below are
      // overridden later in the same block, which is what makes the pulses
      // last exactly one cycle.
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      o_overrun  <= 1'b0;

      case (state)
        WAIT_A: begin
          idle_cnt <= '0;
          if (i_rx_done) begin
            o_alu_a <= i_rx_data;
            state   <= WAIT_B;
          end
        end

        WAIT_B: begin
          // A byte arriving on the expiry cycle wins over the timeout.
          if (i_rx_done) begin
            o_alu_b  <= i_rx_data;
            idle_cnt <= '0;
            state    <= WAIT_OP;
          end else if (idle_cnt == CNT_LAST) begin
            idle_cnt  <= '0;
            o_timeout <= 1'b1;
            state     <= WAIT_A;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        WAIT_OP: begin
          if (i_rx_done) begin
            o_alu_op <= i_rx_data[NB_OP-1:0];
            idle_cnt <= '0;
            state    <= EXEC;
          end else if (idle_cnt == CNT_LAST) begin
            idle_cnt  <= '0;
            o_timeout <= 1'b1;
            state     <= WAIT_A;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        EXEC: begin
          // Operands have been stable for a full cycle, so the ALU output is valid.
          o_tx_data  <= i_alu_result;
          o_tx_start <= 1'b1;
          o_overrun  <= i_rx_done;
          state      <= SEND;
        end

        SEND: begin
          o_overrun <= i_rx_done;
          state     <= WAIT_TX;
        end

        WAIT_TX: begin
          o_overrun <= i_rx_done;
          if (i_tx_done) begin
            idle_cnt <= '0;
            state    <= WAIT_A;
          end
        end

        default: begin
          idle_cnt <= '0;
          state    <= WAIT_A;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed bench for alu_uart_ctrl: a table of complete transactions against a
// small ALU model, plus hand-written sequences for timeout, overrun and reset.
module tb_alu_uart_ctrl;

  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int TMO     = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [NB_DATA-1:0] rx_data;
  logic               rx_done;
  logic [NB_DATA-1:0] alu_result;
  logic               tx_done;
  logic [NB_DATA-1:0] alu_a;
  logic [NB_DATA-1:0] alu_b;
  logic [NB_OP-1:0]   alu_op;
  logic [NB_DATA-1:0] tx_data;
  logic               tx_start;
  logic               busy;
  logic               timeout;
  logic               overrun;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op_byte;
    logic [5:0] exp_op;
    logic [7:0] exp_res;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  // Reference ALU: MIPS-style function codes.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      default: return 8'h00;
    endcase
  endfunction

  assign alu_result = alu_model(alu_a, alu_b, alu_op);

  alu_uart_ctrl #(
    .NB_DATA       (NB_DATA),
    .NB_OP         (NB_OP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .i_alu_result(alu_result),
    .i_tx_done   (tx_done),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_op    (alu_op),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_busy      (busy),
    .o_timeout   (timeout),
    .o_overrun   (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " alu_a"},    32'(alu_a),    32'h0);
    check({tag, " alu_b"},    32'(alu_b),    32'h0);
    check({tag, " alu_op"},   32'(alu_op),   32'h0);
    check({tag, " tx_data"},  32'(tx_data),  32'h0);
    check({tag, " tx_start"}, 32'(tx_start), 32'h0);
    check({tag, " busy"},     32'(busy),     32'h0);
    check({tag, " timeout"},  32'(timeout),  32'h0);
    check({tag, " overrun"},  32'(overrun),  32'h0);
  endtask

  // Full transaction: three bytes, result check, tx_start timing, handshake.
  task automatic run_vec(input vec_t v, input string tag);
    send_byte(v.a);
    send_byte(v.b);
    send_byte(v.op_byte);
    check({tag, " alu_a"},        32'(alu_a),    32'(v.a));
    check({tag, " alu_b"},        32'(alu_b),    32'(v.b));
    check({tag, " alu_op"},       32'(alu_op),   32'(v.exp_op));
    check({tag, " start early"},  32'(tx_start), 32'h0);
    check({tag, " busy exec"},    32'(busy),     32'h1);
    tick();
    check({tag, " start pulse"},  32'(tx_start), 32'h1);
    check({tag, " tx_data"},      32'(tx_data),  32'(v.exp_res));
    tick();
    check({tag, " start low"},    32'(tx_start), 32'h0);
    tick();
    check({tag, " busy wait_tx"}, 32'(busy),     32'h1);
    check({tag, " no restart"},   32'(tx_start), 32'h0);
    pulse_tx_done();
    check({tag, " busy done"},    32'(busy),     32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{8'h03, 8'h0C, 8'h20, 6'h20, 8'h0F};
    vecs[1] = '{8'h05, 8'h01, 8'h22, 6'h22, 8'h04};
    vecs[2] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
    vecs[3] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF};
    vecs[4] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00};
    vecs[5] = '{8'h00, 8'h01, 8'h22, 6'h22, 8'hFF};
    vecs[6] = '{8'h12, 8'h34, 8'hE0, 6'h20, 8'h46};
    vecs[7] = '{8'hAA, 8'h55, 8'h26, 6'h26, 8'hFF};
    vecs[8] = '{8'h3C, 8'h0F, 8'h27, 6'h27, 8'hC0};

    rst     = 1'b0;
    rx_data = '0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    #2 rst = 1'b1;
    tick();

    // Table of complete transactions.
    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Timeout after operand B: 15 silent cycles are tolerated, the 16th expires.
    send_byte(8'h03);
    send_byte(8'h0C);
    for (int i = 0; i < TMO - 1; i++) begin
      check($sformatf("tmo quiet %0d", i), 32'(timeout), 32'h0);
      tick();
    end
    check("tmo last quiet", 32'(timeout), 32'h0);
    tick();
    check("tmo pulse",     32'(timeout), 32'h1);
    check("tmo busy",      32'(busy),    32'h0);
    check("tmo keeps a",   32'(alu_a),   32'h03);
    check("tmo keeps b",   32'(alu_b),   32'h0C);
    tick();
    check("tmo one cycle", 32'(timeout), 32'h0);
    run_vec(vecs[1], "after tmo");

    // Byte arriving on the exact expiry cycle is accepted, no timeout.
    send_byte(8'h21);
    send_byte(8'h10);
    for (int i = 0; i < TMO - 1; i++) tick();
    send_byte(8'h20);
    check("edge no timeout", 32'(timeout), 32'h0);
    check("edge accepted",   32'(busy),    32'h1);
    check("edge op",         32'(alu_op),  32'h20);
    tick();
    check("edge start",      32'(tx_start), 32'h1);
    check("edge result",     32'(tx_data),  32'h31);
    tick();
    pulse_tx_done();
    check("edge idle",       32'(busy),     32'h0);

    // Timeout while waiting for operand B.
    send_byte(8'h77);
    for (int i = 0; i < TMO; i++) tick();
    check("tmo in wait_b", 32'(timeout), 32'h1);
    check("tmo b a kept",  32'(alu_a),   32'h77);

    // Overrun during WAIT_TX, then tx_done returns to normal service.
    send_byte(8'h03);
    send_byte(8'h0C);
    send_byte(8'h20);
    tick();
    tick();
    send_byte(8'hAA);
    check("ovr pulse",   32'(overrun), 32'h1);
    check("ovr a kept",  32'(alu_a),   32'h03);
    check("ovr busy",    32'(busy),    32'h1);
    tick();
    check("ovr one cyc", 32'(overrun), 32'h0);
    pulse_tx_done();
    check("ovr no pulse idle", 32'(overrun), 32'h0);
    run_vec(vecs[0], "after ovr");

    // tx_done while collecting operands is ignored.
    send_byte(8'h05);
    pulse_tx_done();
    send_byte(8'h01);
    pulse_tx_done();
    send_byte(8'h22);
    tick();
    check("stray done result", 32'(tx_data), 32'h04);
    tick();
    pulse_tx_done();

    // Reset asserted in WAIT_TX abandons the transaction.
    send_byte(8'hFF);
    send_byte(8'h01);
    send_byte(8'h20);
    tick();
    tick();
    check("pre-rst busy", 32'(busy), 32'h1);
    #2 rst = 1'b0;
    #1;
    check_all_zero("mid rst");
    #2 rst = 1'b1;
    tick();
    pulse_tx_done();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post rst start %0d", i), 32'(tx_start), 32'h0);
      check($sformatf("post rst busy %0d", i),  32'(busy),     32'h0);
      tick();
    end
    run_vec(vecs[2], "after rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
